mandala_frame_sequencer: RTL
============================

// Module: mandala_frame_sequencer
// PURPOSE
//  Upstream animation stage for the mandala VGA pattern generator. Watches the
//  sync generator's vsync and produces the per-frame animation state:
//  - pattern phase (angle offset)
//  - colour counter (palette base)
//  - frame counter
//  - one-cycle frame tick
//  Speed, pause, direction and sweep mode come from user inputs (ui_in).
// PARAMETERS
//  PHASE_W    10    width of pattern_phase
//  STEP       1     phase increment per advance; 1..2^PHASE_W-1
//  PHASE_MAX  1023  ping-pong upper turn point; must be >= STEP, < 2^PHASE_W
//  FC_W       16    width of frame_count
// PORTS
//  clk            in   1        pixel clock
//  rst_n          in   1        asynchronous active-low reset
//  vsync          in   1        active-high vsync from hvsync_generator, clk domain
//  cfg_speed      in   3        advance once every cfg_speed+1 frames
//  cfg_pause      in   1        1 = freeze phase/colour advance
//  cfg_reverse    in   1        wrap mode only: 1 = phase counts down
//  cfg_mode       in   2        0 wrap, 1 ping-pong, 2/3 hold
//  pattern_phase  out  PHASE_W  angle offset consumed by the pattern generator
//  color_count    out  8        colour counter; pattern generator uses [7:2]
//  frame_count    out  FC_W     frames seen since reset, wraps
//  sweep_down     out  1        ping-pong FSM state (1 = S_DOWN)
//  frame_tick     out  1        one-cycle pulse per frame
// BEHAVIOUR
//  - Reset (async, rst_n=0): all outputs 0, vsync_q=0, div_cnt=0, FSM=S_UP.
//  - Edge detect: rise = vsync & ~vsync_q; vsync_q <= vsync every clk.
//    vsync held high any number of cycles = exactly one rise.
//  - All updates are registered on the clk edge where rise=1. Latency is 1.
//    frame_tick and the new phase/colour/count appear together in the next
//    cycle. frame_tick is high for exactly 1 cycle.
//  - frame_count += 1 (mod 2^FC_W) and frame_tick pulse on every rise,
//    regardless of pause or mode.
//  - Divider on rise with cfg_pause=0:
//    - if div_cnt >= cfg_speed: div_cnt <= 0 and ADVANCE.
//    - else div_cnt += 1.
//    - The >= compare handles cfg_speed lowered mid-count.
//  - cfg_pause=1: div_cnt, phase, colour and FSM all hold. Config inputs are
//    sampled only on rise; no other qualification.
//  - ADVANCE:
//    - color_count += 1 (mod 256) in every mode except hold.
//    - phase changes per cfg_mode as below.
//  - Mode 0 (wrap):
//    - reverse=0: phase <= phase+STEP (mod 2^PHASE_W).
//    - reverse=1: phase <= phase-STEP (mod 2^PHASE_W).
//    - FSM state untouched.
//  - Mode 1 (ping-pong FSM, cfg_reverse ignored):
//    - S_UP: if phase+STEP > PHASE_MAX (compare at PHASE_W+1 bits), then
//      phase <= PHASE_MAX and go to S_DOWN; else phase += STEP.
//    - S_DOWN: if phase < STEP, then phase <= 0 and go to S_UP;
//      else phase -= STEP.
//    - Entering mode 1 with phase > PHASE_MAX: the first ADVANCE clamps to
//      PHASE_MAX and goes to S_DOWN (covered by the S_UP rule; in S_DOWN it
//      steps down normally).
//  - Mode 2/3 (hold): no change to phase, colour or FSM. The divider still runs.
//  - sweep_down = (FSM == S_DOWN), registered.
//  - Reset asserted mid-frame: outputs clear immediately (async). After release,
//    the first rise counts as frame 1. A vsync already high at release produces
//    a rise on the first clk, since vsync_q=0.
// TESTING
//  1. Defaults, mode 0, speed 0, 3 vsync pulses -> phase 3, color 3, frame_count 3,
//     3 single-cycle frame_ticks, each 1 clk after its rise.
//  2. speed=2, 6 pulses -> phase 1 after pulse 3, 2 after pulse 6; color 2;
//     frame_count 6.
//  3. Mode 0, reverse=1 from reset, 1 pulse -> phase 1023. Mode 0 fwd from 1023
//     -> wraps to 0.
//  4. STEP=2, PHASE_MAX=7, mode 1, 9 pulses -> phase 2,4,6,7,5,3,1,0,2.
//     sweep_down rises on the 7 step and falls on the 0 step.
//  5. Pause=1 over 4 pulses mid-divide (div_cnt=1, speed=2) -> phase/color/div held,
//     frame_count +4. Unpause, 1 pulse -> phase +1.
//  6. vsync high 50 clks -> one tick, one advance. rst_n low mid-count -> all outputs
//     0 same cycle, no clk edge needed.

Source files
------------

// File: rtl/mandala_frame_if.sv
// Bundle between the sync generator / user controls and the frame sequencer.
//   vsync         : active-high vsync, clk domain
//   cfg_speed     : advance once every cfg_speed+1 frames
//   cfg_pause     : freeze phase/colour/divider/FSM
//   cfg_reverse   : wrap mode count direction (1 = down)
//   cfg_mode      : 0 wrap, 1 ping-pong, 2/3 hold
//   pattern_phase : angle offset for the pattern generator
//   color_count   : palette base counter
//   frame_count   : frames seen since reset
//   sweep_down    : ping-pong direction state
//   frame_tick    : one-cycle pulse per frame
// master = control/sync side, slave = sequencer side.
interface mandala_frame_if #(
    parameter int unsigned PHASE_W = 10,
    parameter int unsigned FC_W    = 16
);
    logic               vsync;
    logic [2:0]         cfg_speed;
    logic               cfg_pause;
    logic               cfg_reverse;
    logic [1:0]         cfg_mode;
    logic [PHASE_W-1:0] pattern_phase;
    logic [7:0]         color_count;
    logic [FC_W-1:0]    frame_count;
    logic               sweep_down;
    logic               frame_tick;

    modport master (
        output vsync, cfg_speed, cfg_pause, cfg_reverse, cfg_mode,
        input  pattern_phase, color_count, frame_count, sweep_down, frame_tick
    );

    modport slave (
        input  vsync, cfg_speed, cfg_pause, cfg_reverse, cfg_mode,
        output pattern_phase, color_count, frame_count, sweep_down, frame_tick
    );
endinterface

// File: rtl/mandala_frame_sequencer.sv
// Per-frame animation state for the mandala pattern generator.
// Detects the rising edge of vsync and, one clock later, presents the new
// pattern phase, colour counter, frame counter and a one-cycle frame tick.
// Ports:
//   clk   : pixel clock
//   rst_n : asynchronous active-low reset
//   bus   : mandala_frame_if slave (vsync + cfg inputs, animation outputs)
module mandala_frame_sequencer #(
    parameter int unsigned PHASE_W   = 10,
    parameter int unsigned STEP      = 1,
    parameter int unsigned PHASE_MAX = 1023,
    parameter int unsigned FC_W      = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    mandala_frame_if.slave  bus
);

    localparam logic [0:0] S_UP   = 1'b0;
    localparam logic [0:0] S_DOWN = 1'b1;

    localparam logic [PHASE_W-1:0] STEP_P  = PHASE_W'(STEP);
    localparam logic [PHASE_W:0]   STEP_X  = (PHASE_W + 1)'(STEP);
    localparam logic [PHASE_W:0]   PMAX_X  = (PHASE_W + 1)'(PHASE_MAX);
    localparam logic [PHASE_W-1:0] PMAX_P  = PHASE_W'(PHASE_MAX);

    logic               vsync_q;
    logic               rise;
    logic [2:0]         div_q, div_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [7:0]         color_q, color_d;
    logic [FC_W-1:0]    fc_q;
    logic               tick_q;
    logic [0:0]         state_q, state_d;
    logic               advance;
    logic [PHASE_W:0]   phase_up;

    assign rise     = bus.vsync & ~vsync_q;
    // One extra bit so phase+STEP cannot wrap before the turn-point compare.
    assign phase_up = {1'b0, phase_q} + STEP_X;

    always_comb begin
        div_d   = div_q;
        phase_d = phase_q;
        color_d = color_q;
        state_d = state_q;
        advance = 1'b0;

        if (rise && !bus.cfg_pause) begin
            // >= rather than == so a speed lowered mid-count still fires.
            if (div_q >= bus.cfg_speed) begin
                div_d   = 3'd0;
                advance = 1'b1;
            end else begin
                div_d = div_q + 3'd1;
            end
        end

        if (advance) begin
            case (bus.cfg_mode)
                2'd0: begin
                    color_d = color_q + 8'd1;
                    if (bus.cfg_reverse) begin
                        phase_d = phase_q - STEP_P;
                    end else begin
                        phase_d = phase_q + STEP_P;
                    end
                end
                2'd1: begin
                    color_d = color_q + 8'd1;
                    if (state_q == S_UP) begin
                        // Also clamps a phase already above PHASE_MAX on entry.
                        if (phase_up > PMAX_X) begin
                            phase_d = PMAX_P;
                            state_d = S_DOWN;
                        end else begin
                            phase_d = phase_up[PHASE_W-1:0];
                        end
                    end else begin
                        if (phase_q < STEP_P) begin
                            phase_d = '0;
                            state_d = S_UP;
                        end else begin
                            phase_d = phase_q - STEP_P;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q <= 1'b0;
            div_q   <= 3'd0;
            phase_q <= '0;
            color_q <= 8'd0;
            fc_q    <= '0;
            tick_q  <= 1'b0;
            state_q <= S_UP;
        end else begin
            vsync_q <= bus.vsync;
            tick_q  <= rise;
            div_q   <= div_d;
            phase_q <= phase_d;
            color_q <= color_d;
            state_q <= state_d;
            if (rise) begin
                fc_q <= fc_q + 1'b1;
            end
        end
    end

    assign bus.pattern_phase = phase_q;
    assign bus.color_count   = color_q;
    assign bus.frame_count   = fc_q;
    assign bus.frame_tick    = tick_q;
    assign bus.sweep_down    = (state_q == S_DOWN);

endmodule
